mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_byte_lane_assembler.sv | 39 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM states, grant owner, access size codes
// and the IO region, plus the beat-count rule.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Byte address bits [17:16] of an IO access.
    localparam logic [1:0] IO_REGION = 2'b11;

    function automatic logic [2:0] beat_count(input grant_e grant, input logic [1:0] size);
        logic [2:0] n;
        if (grant == GNT_IF) begin
            n = 3'd4;
        end else begin
            case (size)
                SIZE_BYTE: n = 3'd1;
                SIZE_HALF: n = 3'd2;
                default:   n = 3'd4;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter_byte_lane_assembler.sv
// Collects read bytes into their little-endian lanes and presents the zero-extended result,
// with the byte currently on the bus already merged in.
module byte_lane_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        capture,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    input  logic [1:0]  size,
    output logic [31:0] result
);

    logic [31:0] bytes_q, bytes_d;
    logic [31:0] merged;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        merged = bytes_q;
        merged[{lane, 3'b000} +: 8] = din;
        bytes_d = capture ? merged : bytes_q;
        case (size)
            SIZE_BYTE: result = {24'd0, merged[7:0]};
            SIZE_HALF: result = {16'd0, merged[15:0]};
            default:   result = merged;
        endcase
    end

    // NOTE: this is a plain register (not a RAM), so it is reset like any other flop.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bytes_q <= '0;
        end else begin
            bytes_q <= bytes_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto a byte-wide RAM with a
// one-cycle read latency, splitting each access into little-endian byte beats.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_FIRST = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        busy
);

    state_e      state_q, state_d;
    grant_e      grant_q, grant_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] base_q, base_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic [2:0]  n_beats, addr_idx;
    logic [31:0] beat_addr, assembled;
    logic        capture, write_ok, if_ok, mem_ok;

    assign n_beats = beat_count(grant_q, size_q);

    // While reading, cnt_q counts issued addresses. On a stall (and on the final capture
    // cycle) the bus points back at the in-flight byte so the RAM keeps returning it.
    always_comb begin
        addr_idx = cnt_q;
        if (state_q == ST_READ && cnt_q != 3'd0 && (!rdy_in || cnt_q == n_beats)) begin
            addr_idx = cnt_q - 3'd1;
        end
    end

    assign beat_addr = base_q + {29'd0, addr_idx};
    assign write_ok  = (state_q == ST_WRITE) && rdy_in &&
                       !((beat_addr[17:16] == IO_REGION) && io_buffer_full);
    assign capture   = (state_q == ST_READ) && rdy_in && (cnt_q != 3'd0);

    byte_lane_assembler u_assembler (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .capture (capture),
        .lane    (cnt_q[1:0] - 2'd1),
        .din     (ram_din),
        .size    (size_q),
        .result  (assembled)
    );

    assign ram_addr  = (state_q == ST_IDLE) ? '0 : beat_addr;
    assign ram_wr    = write_ok;
    assign ram_dout  = (state_q == ST_WRITE) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign busy      = (state_q != ST_IDLE);

    // A port that is seeing its done pulse still holds its request; ignore it that cycle.
    assign mem_ok = mem_req && !mem_done_q;
    assign if_ok  = if_req && !if_done_q && !if_cancel;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 3'd0;
                    if (mem_ok && (MEM_FIRST != 0 || !if_ok)) begin
                        grant_d = GNT_MEM;
                        base_d  = mem_addr;
                        size_d  = mem_size;
                        wdata_d = mem_wdata;
                        state_d = mem_we ? ST_WRITE : ST_READ;
                    end else if (if_ok) begin
                        grant_d = GNT_IF;
                        base_d  = if_addr;
                        size_d  = SIZE_WORD;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if (grant_q == GNT_IF && if_cancel) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == n_beats) begin
                        state_d = ST_IDLE;
                        if (grant_q == GNT_IF) begin
                            if_data_d = assembled;
                            if_done_d = 1'b1;
                        end else begin
                            mem_rdata_d = assembled;
                            mem_done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (write_ok) begin
                        if (cnt_q == n_beats - 3'd1) begin
                            state_d    = ST_IDLE;
                            mem_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_IF;
            cnt_q       <= '0;
            base_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, tie-break, store, IO back-pressure, cancel,
// stall and mid-transfer reset, against a byte RAM model with one-cycle read latency.
module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ram [0:262143];
    logic [7:0] st_bytes [4];

    mem_arbiter #(.MEM_FIRST(1)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_addr       (ram_addr),
        .ram_wr         (ram_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_cancel      (if_cancel),
        .if_done        (if_done),
        .if_data        (if_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_done       (mem_done),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        ram_din <= ram[ram_addr[17:0]];
        if (ram_wr) ram[ram_addr[17:0]] <= ram_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h00; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        ram[18'h200] = 8'h93; ram[18'h201] = 8'h00; ram[18'h202] = 8'h10; ram[18'h203] = 8'h00;
        ram[18'h2000] = 8'hFF;
        st_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        // Reset state
        tick(); tick(); settle();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_mem_done", {31'd0, mem_done}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        tick(); rst_in = 1'b1; settle();
        check("rst_release_busy", {31'd0, busy}, 32'd0);

        // Word fetch at 0x100
        tick(); if_req = 1'b1; if_addr = 32'h100; settle();
        check("fetch_c0_busy", {31'd0, busy}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(); settle();
            check($sformatf("fetch_addr_c%0d", k), ram_addr, 32'h100 + k - 1);
        end
        tick(); settle();
        check("fetch_c5_done", {31'd0, if_done}, 32'd0);
        tick(); settle();
        check("fetch_c6_done", {31'd0, if_done}, 32'd1);
        check("fetch_data", if_data, 32'h0000_0013);
        check("fetch_c6_idle", {31'd0, busy}, 32'd0);
        tick(); if_req = 1'b0; settle();
        check("fetch_no_reissue", {31'd0, busy}, 32'd0);
        check("fetch_pulse_width", {31'd0, if_done}, 32'd0);

        // Tie: lb at 0x2000 wins, then the fetch at 0x200 is granted
        tick();
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h2000;
        settle();
        tick(); settle();
        check("tie_mem_addr", ram_addr, 32'h2000);
        tick(); settle();
        check("tie_c2_done", {31'd0, mem_done}, 32'd0);
        tick(); settle();
        check("tie_mem_done", {31'd0, mem_done}, 32'd1);
        check("tie_mem_rdata", mem_rdata, 32'h0000_00FF);
        tick(); mem_req = 1'b0; settle();
        check("tie_fetch_addr", ram_addr, 32'h200);
        repeat (4) begin tick(); settle(); end
        tick(); settle();
        check("tie_if_done", {31'd0, if_done}, 32'd1);
        check("tie_if_data", if_data, 32'h0010_0093);
        tick(); if_req = 1'b0; settle();
        check("rdata_hold", mem_rdata, 32'h0000_00FF);

        // sw 0xDEADBEEF at 0x1FFE
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h1FFE; mem_wdata = 32'hDEAD_BEEF;
        settle();
        check("st_c0_wr", {31'd0, ram_wr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check($sformatf("st_wr_c%0d", i + 1), {31'd0, ram_wr}, 32'd1);
            check($sformatf("st_addr_c%0d", i + 1), ram_addr, 32'h1FFE + i);
            check($sformatf("st_dout_c%0d", i + 1), {24'd0, ram_dout}, {24'd0, st_bytes[i]});
        end
        tick(); settle();
        check("st_done", {31'd0, mem_done}, 32'd1);
        check("st_done_wr", {31'd0, ram_wr}, 32'd0);
        tick(); mem_req = 1'b0; mem_we = 1'b0; settle();

        // sb 0x41 to the IO region while the UART buffer is full
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h0003_0000; mem_wdata = 32'h41;
        io_buffer_full = 1'b1;
        settle();
        for (int k = 1; k <= 3; k++) begin
            tick(); settle();
            check($sformatf("io_hold_wr_c%0d", k), {31'd0, ram_wr}, 32'd0);
        end
        check("io_hold_busy", {31'd0, busy}, 32'd1);
        tick(); io_buffer_full = 1'b0; settle();
        check("io_wr", {31'd0, ram_wr}, 32'd1);
        check("io_addr", ram_addr, 32'h0003_0000);
        check("io_dout", {24'd0, ram_dout}, 32'h41);
        tick(); settle();
        check("io_done", {31'd0, mem_done}, 32'd1);
        check("io_done_wr", {31'd0, ram_wr}, 32'd0);
        tick(); mem_req = 1'b0; mem_we = 1'b0; settle();

        // Cancel in fetch cycle 2
        tick(); if_req = 1'b1; if_addr = 32'h100; settle();
        tick(); settle();
        tick(); if_cancel = 1'b1; settle();
        check("cancel_c2_busy", {31'd0, busy}, 32'd1);
        tick(); if_cancel = 1'b0; if_req = 1'b0; settle();
        check("cancel_idle", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            check($sformatf("cancel_no_done_%0d", k), {31'd0, if_done}, 32'd0);
        end

        // Cancel in IDLE suppresses the grant; the fetch goes once it drops
        tick(); if_req = 1'b1; if_addr = 32'h100; if_cancel = 1'b1; settle();
        tick(); if_cancel = 1'b0; settle();
        check("cancel_suppress", {31'd0, busy}, 32'd0);
        repeat (5) begin tick(); settle(); end
        tick(); settle();
        check("post_cancel_done", {31'd0, if_done}, 32'd1);
        check("post_cancel_data", if_data, 32'h0000_0013);
        tick(); if_req = 1'b0; settle();

        // rdy_in low for 2 cycles during beat 2 of a fetch
        tick(); if_req = 1'b1; if_addr = 32'h200; settle();
        tick(); settle();
        tick(); rdy_in = 1'b0; settle();
        check("stall_busy", {31'd0, busy}, 32'd1);
        tick(); settle();
        check("stall_wr", {31'd0, ram_wr}, 32'd0);
        tick(); rdy_in = 1'b1; settle();
        tick(); settle();
        tick(); settle();
        check("stall_c6_done", {31'd0, if_done}, 32'd0);
        tick(); settle();
        check("stall_c7_done", {31'd0, if_done}, 32'd0);
        tick(); settle();
        check("stall_c8_done", {31'd0, if_done}, 32'd1);
        check("stall_data", if_data, 32'h0010_0093);
        tick(); if_req = 1'b0; settle();

        // Reset in store cycle 2
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h1000; mem_wdata = 32'h1122_3344;
        settle();
        tick(); settle();
        tick(); settle();
        check("rstx_wr_c2", {31'd0, ram_wr}, 32'd1);
        check("rstx_addr_c2", ram_addr, 32'h1001);
        check("rstx_dout_c2", {24'd0, ram_dout}, 32'h33);
        #1 rst_in = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        check("rstx_wr", {31'd0, ram_wr}, 32'd0);
        check("rstx_addr", ram_addr, 32'd0);
        check("rstx_dout", {24'd0, ram_dout}, 32'd0);
        check("rstx_busy", {31'd0, busy}, 32'd0);
        check("rstx_if_data", if_data, 32'd0);
        check("rstx_mem_rdata", mem_rdata, 32'd0);
        tick(); tick(); rst_in = 1'b1; settle();
        check("rstx_idle", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            check($sformatf("rstx_no_done_%0d", k), {31'd0, mem_done}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
